// File: rtl/risky_mmio_pkg.sv
// Shared constants and types for the risky MMIO console block.
package risky_mmio_pkg;

  // Bus region codes carried in mem_addr[31:26]
  localparam logic [5:0] REGION_ROM  = 6'd0;
  localparam logic [5:0] REGION_RAM  = 6'd1;
  localparam logic [5:0] REGION_MMIO = 6'd2;

  // Word offsets of the console registers within the region
  localparam logic [25:0] OFF_EXIT   = 26'd0;
  localparam logic [25:0] OFF_RETVAL = 26'd1;
  localparam logic [25:0] OFF_TXDATA = 26'd2;
  localparam logic [25:0] OFF_TXGO   = 26'd3;
  localparam logic [25:0] OFF_STATUS = 26'd4;

  // STATUS register bit positions
  localparam int STAT_FULL  = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_BUSY  = 2;
  localparam int STAT_OVF   = 3;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/risky_uart_tx.sv
// 8N1 serializer with a valid/ready byte input and a registered line output.
//
// state | meaning
// IDLE  | line high, waiting for a byte
// START | start bit (low) for one bit period
// DATA  | eight data bits, LSB first
// STOP  | stop bit (high); on its last cycle the next byte may be taken
module risky_uart_tx
  import risky_mmio_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       tx,
  output logic       busy
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LOAD = BW'(CLKS_PER_BIT - 1);

  uart_state_t   state;
  logic [BW-1:0] baud;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          baud_tc;

  assign baud_tc  = (baud == '0);
  // A byte is taken when idle, or on the final stop cycle so frames abut.
  assign in_ready = (state == UART_IDLE) || ((state == UART_STOP) && baud_tc);
  assign busy     = (state != UART_IDLE);

  // Serializer FSM: baud down-counter paces each bit, bit counter walks the data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= UART_IDLE;
      baud    <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      tx      <= 1'b1;
    end else begin
      case (state)
        UART_IDLE: begin
          if (in_valid) begin
            state <= UART_START;
            shift <= in_data;
            baud  <= BAUD_LOAD;
            tx    <= 1'b0;
          end
        end
        UART_START: begin
          if (baud_tc) begin
            state   <= UART_DATA;
            baud    <= BAUD_LOAD;
            bit_cnt <= 3'd7;
            tx      <= shift[0];
          end else begin
            baud <= baud - 1'b1;
          end
        end
        UART_DATA: begin
          if (baud_tc) begin
            baud <= BAUD_LOAD;
            if (bit_cnt == 3'd0) begin
              state <= UART_STOP;
              tx    <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt - 1'b1;
              shift   <= shift >> 1;
              tx      <= shift[1];
            end
          end else begin
            baud <= baud - 1'b1;
          end
        end
        UART_STOP: begin
          if (baud_tc) begin
            if (in_valid) begin
              state <= UART_START;
              shift <= in_data;
              baud  <= BAUD_LOAD;
              tx    <= 1'b0;
            end else begin
              state <= UART_IDLE;
            end
          end else begin
            baud <= baud - 1'b1;
          end
        end
        default: begin
          state <= UART_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/risky_mmio_console.sv
// MMIO console: exit/retval registers, TX byte FIFO and UART transmitter.
module risky_mmio_console
  import risky_mmio_pkg::*;
#(
  parameter logic [5:0] REGION       = REGION_MMIO,
  parameter int         CLKS_PER_BIT = 16,
  parameter int         FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mem_addr,
  inout  wire  [31:0] mem_data,
  input  logic        mem_oe,
  input  logic        mem_we,
  output logic        uart_tx,
  output logic        halt,
  output logic [31:0] exit_code
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic          sel, wr_en, rd_en;
  logic [25:0]   off;
  logic [31:0]   wdata, rdata;
  logic [31:0]   retval;
  logic [7:0]    txdata;
  logic          overflow;
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty, push_req, push, pop;
  logic          uart_ready, uart_busy;
  logic [3:0]    status;

  assign sel   = (mem_addr[31:26] == REGION);
  assign off   = mem_addr[25:0];
  assign wr_en = mem_we & sel;
  assign rd_en = mem_oe & sel;
  assign wdata = mem_data;

  assign full     = (count == DEPTH_C);
  assign empty    = (count == '0);
  assign pop      = uart_ready & ~empty;
  assign push_req = wr_en && (off == OFF_TXGO) && (wdata != 32'd0);
  // A full FIFO still accepts a byte when the serializer drains one on the same edge.
  assign push     = push_req && (!full || pop);

  assign exit_code = retval;

  // Register file writes, FIFO pointer/count bookkeeping and sticky overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      halt     <= 1'b0;
      retval   <= '0;
      txdata   <= '0;
      overflow <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (wr_en) begin
        case (off)
          OFF_EXIT:   if (wdata != 32'd0) halt <= 1'b1;
          OFF_RETVAL: retval <= wdata;
          OFF_TXDATA: txdata <= wdata[7:0];
          default: ;
        endcase
      end
      if (wr_en && (off == OFF_STATUS)) begin
        overflow <= 1'b0;
      end else if (push_req && !push) begin
        overflow <= 1'b1;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // FIFO storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= txdata;
  end

  // Combinational read mux; nothing here has a read side effect.
  always_comb begin
    status             = '0;
    status[STAT_FULL]  = full;
    status[STAT_EMPTY] = empty;
    status[STAT_BUSY]  = uart_busy;
    status[STAT_OVF]   = overflow;
    rdata = '0;
    case (off)
      OFF_EXIT:   rdata = {31'd0, halt};
      OFF_RETVAL: rdata = retval;
      OFF_TXDATA: rdata = {24'd0, txdata};
      OFF_TXGO:   rdata = {31'd0, full};
      OFF_STATUS: rdata = {28'd0, status};
      default:    rdata = '0;
    endcase
  end

  assign mem_data = rd_en ? rdata : 32'bz;

  risky_uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (~empty),
    .in_data  (fifo_mem[rd_ptr]),
    .in_ready (uart_ready),
    .tx       (uart_tx),
    .busy     (uart_busy)
  );

endmodule

// File: tb/tb_risky_mmio_console.sv
// Directed bench for risky_mmio_console at CLKS_PER_BIT=4, FIFO_DEPTH=8.
module tb_risky_mmio_console;
  import risky_mmio_pkg::*;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] mem_addr;
  wire  [31:0] mem_data;
  logic        mem_oe, mem_we;
  logic        uart_tx, halt;
  logic [31:0] exit_code;
  logic        tb_drv;
  logic [31:0] tb_wdata;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] v;
  logic        seen_low;
  logic [7:0]  ovf_bytes [10];

  assign mem_data = tb_drv ? tb_wdata : 32'bz;

  risky_mmio_console #(
    .REGION       (REGION_MMIO),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_oe    (mem_oe),
    .mem_we    (mem_we),
    .uart_tx   (uart_tx),
    .halt      (halt),
    .exit_code (exit_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_write_rgn(input logic [5:0] rgn, input logic [25:0] off, input logic [31:0] data);
    mem_addr = {rgn, off};
    tb_wdata = data;
    tb_drv   = 1'b1;
    mem_we   = 1'b1;
    @(posedge clk);
    #1;
    mem_we   = 1'b0;
    tb_drv   = 1'b0;
  endtask

  task automatic wr(input logic [25:0] off, input logic [31:0] data);
    bus_write_rgn(REGION_MMIO, off, data);
  endtask

  task automatic rd_check(input string tag, input logic [25:0] off, input logic [31:0] exp);
    logic [31:0] val;
    mem_addr = {REGION_MMIO, off};
    mem_oe   = 1'b1;
    #1;
    val      = mem_data;
    mem_oe   = 1'b0;
    check(tag, val, exp);
  endtask

  // Called #1 after the edge that starts the frame; returns #1 after the edge ending it.
  task automatic check_frame(input logic [7:0] b);
    logic [9:0] bits;
    bits = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < CPB; c++) begin
        check($sformatf("frame_%h_bit%0d", b, i), {31'd0, uart_tx}, {31'd0, bits[i]});
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ovf_bytes[0] = 8'hC3; ovf_bytes[1] = 8'h11; ovf_bytes[2] = 8'h22; ovf_bytes[3] = 8'h33;
    ovf_bytes[4] = 8'h44; ovf_bytes[5] = 8'h55; ovf_bytes[6] = 8'h66; ovf_bytes[7] = 8'h77;
    ovf_bytes[8] = 8'h88; ovf_bytes[9] = 8'h99;
    rst_n = 1'b0; mem_addr = '0; mem_oe = 1'b0; mem_we = 1'b0; tb_drv = 1'b0; tb_wdata = '0;

    // Reset
    repeat (2) @(posedge clk);
    #1;
    check("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
    check("rst_halt", {31'd0, halt}, 32'd0);
    check("rst_exit_code", exit_code, 32'd0);
    check("rst_bus_hiz", {31'd0, (mem_data === 32'bz)}, 32'd1);
    rst_n = 1'b1;
    rd_check("rst_status", OFF_STATUS, 32'h2);

    // Register access, decode and region select
    wr(OFF_RETVAL, 32'h1234_5678);
    check("retval_exit_code", exit_code, 32'h1234_5678);
    rd_check("retval_read", OFF_RETVAL, 32'h1234_5678);
    bus_write_rgn(REGION_RAM, OFF_RETVAL, 32'hDEAD_BEEF);
    rd_check("other_region_write_ignored", OFF_RETVAL, 32'h1234_5678);
    mem_addr = {REGION_RAM, OFF_STATUS};
    mem_oe   = 1'b1;
    #1;
    check("other_region_read_hiz", {31'd0, (mem_data === 32'bz)}, 32'd1);
    mem_oe   = 1'b0;
    wr(26'd7, 32'hFFFF_FFFF);
    rd_check("unmapped_read", 26'd7, 32'd0);
    wr(OFF_TXDATA, 32'hCAFE_BE41);
    rd_check("txdata_8bit", OFF_TXDATA, 32'h41);
    wr(OFF_TXGO, 32'd0);
    @(posedge clk);
    #1;
    rd_check("txgo_zero_no_push", OFF_STATUS, 32'h2);
    check("txgo_zero_line_idle", {31'd0, uart_tx}, 32'd1);

    // Single frame 0x41: line falls after the edge following the TXGO edge
    wr(OFF_TXGO, 32'd1);
    check("push_edge_line_high", {31'd0, uart_tx}, 32'd1);
    @(posedge clk);
    #1;
    check_frame(8'h41);
    check("after_41_line", {31'd0, uart_tx}, 32'd1);
    rd_check("after_41_status", OFF_STATUS, 32'h2);

    // Three contiguous frames
    fork
      begin
        repeat (3) @(posedge clk);
        #1;
        check_frame(8'h55);
        check_frame(8'hAA);
        check_frame(8'h0F);
      end
      begin
        wr(OFF_TXDATA, 32'h55); wr(OFF_TXGO, 32'd1);
        wr(OFF_TXDATA, 32'hAA); wr(OFF_TXGO, 32'd1);
        wr(OFF_TXDATA, 32'h0F); wr(OFF_TXGO, 32'd1);
      end
    join
    rd_check("b2b_done_status", OFF_STATUS, 32'h2);

    // Overflow while the first frame is in flight, plus exit/retval while draining
    fork
      begin
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 9; k++) check_frame(ovf_bytes[k]);
      end
      begin
        for (int k = 0; k < 10; k++) begin
          wr(OFF_TXDATA, {24'd0, ovf_bytes[k]});
          wr(OFF_TXGO, 32'd1);
        end
        rd_check("txgo_full", OFF_TXGO, 32'd1);
        rd_check("status_full_ovf", OFF_STATUS, 32'hD);
        wr(OFF_STATUS, 32'd0);
        rd_check("status_ovf_cleared", OFF_STATUS, 32'h5);
        rd_check("exit_read_0", OFF_EXIT, 32'd0);
        wr(OFF_RETVAL, 32'h2A);
        wr(OFF_EXIT, 32'd0);
        check("halt_after_exit0", {31'd0, halt}, 32'd0);
        wr(OFF_EXIT, 32'd1);
        check("halt_after_exit1", {31'd0, halt}, 32'd1);
        check("exit_code_2a", exit_code, 32'h2A);
        rd_check("exit_read_1", OFF_EXIT, 32'd1);
      end
    join
    rd_check("drained_status", OFF_STATUS, 32'h2);
    check("halt_sticky", {31'd0, halt}, 32'd1);

    // Reset in the middle of a frame with one byte still queued
    wr(OFF_TXDATA, 32'hF0);
    wr(OFF_TXGO, 32'd1);
    wr(OFF_TXGO, 32'd1);
    repeat (8) @(posedge clk);
    #1;
    check("mid_data_line", {31'd0, uart_tx}, 32'd0);
    rd_check("mid_data_status", OFF_STATUS, 32'h4);
    rst_n = 1'b0;
    wr(OFF_RETVAL, 32'h77);
    check("rst_mid_line", {31'd0, uart_tx}, 32'd1);
    rd_check("rst_mid_status", OFF_STATUS, 32'h2);
    check("rst_over_write", exit_code, 32'd0);
    check("rst_mid_halt", {31'd0, halt}, 32'd0);
    rst_n = 1'b1;
    seen_low = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (uart_tx !== 1'b1) seen_low = 1'b1;
    end
    check("no_frame_after_reset", {31'd0, seen_low}, 32'd0);
    rd_check("post_reset_status", OFF_STATUS, 32'h2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
